// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble injection on
// stall or branch flush, and a saturating bubble counter.
module id_ex_pipeline_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [7:0]        id_ctrl,
  input  logic              id_regwrite,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [7:0]        ex_ctrl,
  output logic              ex_regwrite,
  output logic              stall_o,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int unsigned MEMREAD_BIT = 2;

  logic hz;
  logic load_bubble;

  // Load in EX whose destination (rt) is a source of the instruction in ID.
  always_comb begin
    hz = id_valid & ex_valid & ex_ctrl[MEMREAD_BIT]
         & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    stall_o     = hz & ~flush_i;
    load_bubble = flush_i | hz;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
      ex_ctrl     <= '0;
      ex_regwrite <= 1'b0;
      bubble_cnt  <= '0;
    end else begin
      // Payload fields always follow ID; they are don't-care inside a bubble.
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_imm     <= id_imm;
      if (load_bubble) begin
        ex_valid    <= 1'b0;
        ex_ctrl     <= '0;
        ex_regwrite <= 1'b0;
        if (bubble_cnt != '1) begin
          bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
      end else begin
        ex_valid    <= id_valid;
        ex_ctrl     <= id_valid ? id_ctrl : 8'h00;
        ex_regwrite <= id_regwrite & id_valid;
      end
    end
  end

endmodule
